rail_sequencer: RTL and testbench
=================================

RAIL_SEQUENCER -- requirements
Module: rail_sequencer

Interface
REQ-001 SHALL have parameter N_RAILS, default 4, meaning the number of sequenced rails (2..8); rail 0 powers up first.
REQ-002 SHALL have parameter TW, default 8, meaning the width of each per-rail delay field and of the delay timer.
REQ-003 SHALL have parameter PG_TO, default 15, meaning the maximum cycles to wait for pgood after a rail's delay expires.
REQ-004 clk  input  1  system clock; all logic on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 on_sw  input  1  system-on request; level-sensitive.
REQ-007 lp_sw  input  1  low-power request; level-sensitive.
REQ-008 lb_sw  input  1  low-battery indication; forces full shutdown.
REQ-009 dly_cfg  input  N_RAILS*TW  per-rail settle delay; field i occupies bits [i*TW +: TW].
REQ-010 lp_keep  input  N_RAILS  rails that stay enabled in low-power mode.
REQ-011 pgood  input  N_RAILS  power-good from each rail.
REQ-012 rail_en  output  N_RAILS  rail enables, registered.
REQ-013 state  output  3  FSM state: OFF=0, UP=1, ACTIVE=2, DOWN=3, LP=4, FAULT=5.
REQ-014 ready  output  1  high while state is ACTIVE.
REQ-015 fault  output  1  high while state is FAULT.
REQ-016 fault_rail  output  N_RAILS  one-hot rail that caused the fault; holds its value until the next FAULT entry or reset.

Function
REQ-017 Step timing: a step enables or disables one rail, loads the timer with dly_cfg[i], and decrements the timer once per cycle; the step completes on the cycle after the timer reaches 0, so a step takes dly_cfg[i]+1 cycles minimum.
REQ-018 Up-steps: an up-step additionally requires pgood[i]=1 once the timer is 0; if pgood[i] stays 0 for PG_TO further cycles, the FSM enters FAULT.
REQ-019 OFF -> UP: when on_sw=1 and lb_sw=0, the FSM enters UP and starts from the lowest disabled rail.
REQ-020 UP: the FSM enables rails in ascending index; after the last rail completes, it enters ACTIVE.
REQ-021 ACTIVE -> DOWN (full): on_sw=0 or lb_sw=1 starts a full power-down in descending index from the highest enabled rail.
REQ-022 ACTIVE -> DOWN (partial): lp_sw=1 starts a descending power-down that skips rails with lp_keep=1 and takes zero cycles for skipped rails; at completion the FSM enters LP.
REQ-023 DOWN completion: a full power-down ends in OFF.
REQ-024 LP: when lp_sw falls with on_sw=1 and lb_sw=0, the FSM enters UP and enables only the disabled rails, in ascending order; on_sw=0 or lb_sw=1 starts a full DOWN.
REQ-025 UP abort: on_sw=0 or lb_sw=1 during UP aborts the current step at once and starts a full DOWN from the highest enabled rail.
REQ-026 Priority: when inputs change simultaneously, lb_sw and on_sw=0 take precedence over lp_sw.
REQ-027 pgood loss: in ACTIVE or LP, pgood=0 on any enabled rail for 2 consecutive cycles sends the FSM to FAULT.
REQ-028 Multiple fault sources: fault_rail records the lowest-index failing rail.
REQ-029 FAULT entry: all rail_en bits clear on the cycle after entry, with no sequencing.
REQ-030 FAULT exit: FAULT is left only when on_sw=0, and the FSM then goes to OFF.
REQ-031 lp_keep sampling: lp_keep is sampled when a partial DOWN starts; later changes do not affect the sequence in progress.
REQ-032 dly_cfg sampling: dly_cfg[i] is sampled when step i starts.
REQ-033 lb_sw hold-off: while lb_sw=1 in OFF, the FSM stays in OFF.
REQ-034 Output timing: all outputs are registered, and ready, fault and state change on the same edge as the state register.

Reset
REQ-035 Asserting reset SHALL immediately force state=OFF, rail_en=0, ready=0, fault=0, fault_rail=0 and timer=0, even mid-sequence.
REQ-036 After reset deasserts, the block SHALL wait in OFF for on_sw=1 and lb_sw=0, and SHALL NOT automatically resume an interrupted sequence.

Verification
REQ-037 Power-up: N_RAILS=4, dly all 3, pgood mirrors rail_en, on_sw rises -> rail_en 0001, 0011, 0111, 1111 at 4-cycle spacing; ready=1 on the cycle after the last step completes.
REQ-038 Low-power round trip: from ACTIVE with lp_keep=0101, lp_sw=1 -> rail 3 then rail 1 disabled, state=LP with rail_en=0101; lp_sw=0 -> rail 1 then rail 3 enabled, back to ACTIVE.
REQ-039 pgood timeout: pgood[2] held 0 during UP -> FAULT after dly+1+PG_TO cycles, rail_en=0000, fault_rail=0100; on_sw=0 -> OFF.
REQ-040 Abort during UP: on_sw falls while rail 2 is in its delay -> DOWN disables rails 2, 1, 0 in turn, ending in OFF with ready never asserted.
REQ-041 Simultaneous lb_sw and lp_sw in ACTIVE: full DOWN runs to OFF; with lb_sw still 1, on_sw=1 keeps the FSM in OFF.
REQ-042 Reset mid-sequence: reset pulsed during DOWN -> all outputs 0 asynchronously; with on_sw=1 after release, a fresh UP starts from rail 0.

Source files
------------

// File: rtl/rail_sequencer.sv
// Power-rail sequencer: ordered rail enable/disable with per-rail settle delay,
// pgood supervision, low-power partial shutdown and a latched fault state.
module rail_sequencer #(
  parameter int N_RAILS = 4,
  parameter int TW      = 8,
  parameter int PG_TO   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  on_sw,
  input  logic                  lp_sw,
  input  logic                  lb_sw,
  input  logic [N_RAILS*TW-1:0] dly_cfg,
  input  logic [N_RAILS-1:0]    lp_keep,
  input  logic [N_RAILS-1:0]    pgood,
  output logic [N_RAILS-1:0]    rail_en,
  output logic [2:0]            state,
  output logic                  ready,
  output logic                  fault,
  output logic [N_RAILS-1:0]    fault_rail
);
  localparam int IW = $clog2(N_RAILS);
  localparam int PW = (PG_TO > 0) ? $clog2(PG_TO + 1) : 1;
  localparam logic [N_RAILS-1:0] RAIL0 = {{(N_RAILS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_OFF = 3'd0, S_UP = 3'd1, S_ACTIVE = 3'd2, S_DOWN = 3'd3, S_LP = 3'd4, S_FAULT = 3'd5
  } state_t;

  function automatic logic [IW-1:0] lowest_zero(input logic [N_RAILS-1:0] m);
    lowest_zero = {IW{1'b0}};
    for (int i = N_RAILS - 1; i >= 0; i--) lowest_zero = m[i] ? lowest_zero : IW'(i);
  endfunction

  function automatic logic [IW-1:0] highest_one(input logic [N_RAILS-1:0] m);
    highest_one = {IW{1'b0}};
    for (int i = 0; i < N_RAILS; i++) highest_one = m[i] ? IW'(i) : highest_one;
  endfunction

  state_t              state_r, state_nx;
  logic [N_RAILS-1:0]  rail_en_r, rail_en_nx;
  logic [TW-1:0]       timer_r, timer_nx;
  logic [IW-1:0]       cur_r, cur_nx;
  logic [PW-1:0]       pg_cnt_r, pg_cnt_nx;
  logic [N_RAILS-1:0]  keep_r, keep_nx;
  logic                full_r, full_nx;
  logic [N_RAILS-1:0]  fault_rail_r, fault_rail_nx;
  logic [N_RAILS-1:0]  loss_r;
  logic                ready_r, fault_r;

  logic                stop_s, go_up_s, go_dn_s, dn_any_s;
  logic [N_RAILS-1:0]  dn_keep_s, dn_mask_s, loss_s, lost_s, lost_low_s;
  logic [IW-1:0]       up_idx_s, dn_idx_s;
  logic [TW-1:0]       dly_a_s [N_RAILS];

  for (genvar g = 0; g < N_RAILS; g++) begin : g_dly
    assign dly_a_s[g] = dly_cfg[g*TW +: TW];
  end

  // Next-rail selection and pgood-loss detection; the skip set is live lp_keep only when a partial DOWN starts.
  always_comb begin
    stop_s = ~on_sw | lb_sw;
    if (state_r == S_DOWN && !full_r && !stop_s) dn_keep_s = keep_r;
    else if (state_r == S_ACTIVE && !stop_s) dn_keep_s = lp_keep;
    else dn_keep_s = {N_RAILS{1'b0}};
    dn_mask_s  = rail_en_r & ~dn_keep_s;
    dn_any_s   = |dn_mask_s;
    dn_idx_s   = highest_one(dn_mask_s);
    up_idx_s   = lowest_zero(rail_en_r);
    if (state_r == S_ACTIVE || state_r == S_LP) loss_s = rail_en_r & ~pgood;
    else loss_s = {N_RAILS{1'b0}};
    lost_s     = loss_s & loss_r;
    lost_low_s = lost_s & (~lost_s + RAIL0);
  end

  // Sequencer next-state: transitions first, then the common step-start action.
  always_comb begin
    state_nx      = state_r;
    rail_en_nx    = rail_en_r;
    timer_nx      = timer_r;
    cur_nx        = cur_r;
    pg_cnt_nx     = pg_cnt_r;
    keep_nx       = keep_r;
    full_nx       = full_r;
    fault_rail_nx = fault_rail_r;
    go_up_s       = 1'b0;
    go_dn_s       = 1'b0;
    case (state_r)
      S_OFF: begin
        if (on_sw && !lb_sw) begin state_nx = S_UP; go_up_s = 1'b1; end
        else state_nx = S_OFF;
      end
      S_UP: begin
        if (stop_s) begin state_nx = S_DOWN; full_nx = 1'b1; go_dn_s = 1'b1; end
        else if (timer_r != {TW{1'b0}}) timer_nx = timer_r - TW'(1);
        else if (pgood[cur_r]) begin
          if (&rail_en_r) state_nx = S_ACTIVE;
          else go_up_s = 1'b1;
        end
        else if (pg_cnt_r == PW'(PG_TO)) begin
          state_nx      = S_FAULT;
          rail_en_nx    = {N_RAILS{1'b0}};
          fault_rail_nx = RAIL0 << cur_r;
        end
        else pg_cnt_nx = pg_cnt_r + PW'(1);
      end
      S_ACTIVE, S_LP: begin
        if (|lost_s) begin
          state_nx      = S_FAULT;
          rail_en_nx    = {N_RAILS{1'b0}};
          fault_rail_nx = lost_low_s;
        end
        else if (stop_s) begin
          full_nx = 1'b1;
          if (dn_any_s) begin state_nx = S_DOWN; go_dn_s = 1'b1; end
          else state_nx = S_OFF;
        end
        else if (state_r == S_ACTIVE && lp_sw) begin
          full_nx = 1'b0;
          if (dn_any_s) begin state_nx = S_DOWN; go_dn_s = 1'b1; end
          else state_nx = S_LP;
        end
        else if (state_r == S_LP && !lp_sw) begin
          if (&rail_en_r) state_nx = S_ACTIVE;
          else begin state_nx = S_UP; go_up_s = 1'b1; end
        end
        else state_nx = state_r;
      end
      S_DOWN: begin
        // A shutdown request turns a partial DOWN into a full one mid-flight.
        full_nx = full_r | stop_s;
        if (timer_r != {TW{1'b0}}) timer_nx = timer_r - TW'(1);
        else if (dn_any_s) go_dn_s = 1'b1;
        else if (full_r || stop_s) state_nx = S_OFF;
        else state_nx = S_LP;
      end
      S_FAULT: begin
        rail_en_nx = {N_RAILS{1'b0}};
        if (!on_sw) state_nx = S_OFF;
        else state_nx = S_FAULT;
      end
      default: begin
        state_nx   = S_OFF;
        rail_en_nx = {N_RAILS{1'b0}};
      end
    endcase
    case ({go_up_s, go_dn_s})
      2'b10: begin
        rail_en_nx[up_idx_s] = 1'b1;
        timer_nx             = dly_a_s[up_idx_s];
        cur_nx               = up_idx_s;
        pg_cnt_nx            = {PW{1'b0}};
      end
      2'b01: begin
        rail_en_nx[dn_idx_s] = 1'b0;
        timer_nx             = dly_a_s[dn_idx_s];
        cur_nx               = dn_idx_s;
        keep_nx              = dn_keep_s;
      end
      default: ;
    endcase
  end

  // State and output registers; ready/fault follow the next state so they move with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_OFF;
      rail_en_r    <= {N_RAILS{1'b0}};
      timer_r      <= {TW{1'b0}};
      cur_r        <= {IW{1'b0}};
      pg_cnt_r     <= {PW{1'b0}};
      keep_r       <= {N_RAILS{1'b0}};
      full_r       <= 1'b0;
      fault_rail_r <= {N_RAILS{1'b0}};
      loss_r       <= {N_RAILS{1'b0}};
      ready_r      <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r      <= state_nx;
      rail_en_r    <= rail_en_nx;
      timer_r      <= timer_nx;
      cur_r        <= cur_nx;
      pg_cnt_r     <= pg_cnt_nx;
      keep_r       <= keep_nx;
      full_r       <= full_nx;
      fault_rail_r <= fault_rail_nx;
      loss_r       <= loss_s;
      ready_r      <= (state_nx == S_ACTIVE);
      fault_r      <= (state_nx == S_FAULT);
    end
  end

  assign rail_en    = rail_en_r;
  assign state      = state_r;
  assign ready      = ready_r;
  assign fault      = fault_r;
  assign fault_rail = fault_rail_r;
endmodule

// File: tb/tb_rail_sequencer.sv
// Randomized bench for rail_sequencer: expected rail enables come from a toggle
// schedule built from the delay arithmetic (each step lasts delay+1 cycles).
module tb_rail_sequencer;
  localparam int N     = 4;
  localparam int TW    = 8;
  localparam int PG_TO = 15;
  localparam logic [2:0] OFF = 3'd0, UP = 3'd1, ACTIVE = 3'd2, DOWN = 3'd3, LP = 3'd4, FLT = 3'd5;

  logic            clk = 1'b0;
  logic            reset, on_sw, lp_sw, lb_sw;
  logic [N*TW-1:0] dly_cfg;
  logic [N-1:0]    lp_keep, pgood, rail_en, fault_rail, pg_kill;
  logic [2:0]      state;
  logic            ready, fault;

  int d [N];
  int pr[$];
  bit pon[$];
  int checks = 0;
  int errors = 0;
  logic [N-1:0] keep, m, low;
  int t2, r;

  always #5 clk = ~clk;
  assign pgood = rail_en & ~pg_kill;

  rail_sequencer #(.N_RAILS(N), .TW(TW), .PG_TO(PG_TO)) dut (
    .clk(clk), .reset(reset), .on_sw(on_sw), .lp_sw(lp_sw), .lb_sw(lb_sw),
    .dly_cfg(dly_cfg), .lp_keep(lp_keep), .pgood(pgood), .rail_en(rail_en),
    .state(state), .ready(ready), .fault(fault), .fault_rail(fault_rail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic new_dly(input int lo);
    for (int i = 0; i < N; i++) begin
      d[i] = int'($urandom_range(4, lo));
      dly_cfg[i*TW +: TW] = TW'(d[i]);
    end
  endtask

  function automatic int plan_total();
    int t = 0;
    foreach (pr[i]) t += d[pr[i]] + 1;
    return t;
  endfunction

  task automatic plan_clear();
    pr.delete();
    pon.delete();
  endtask

  task automatic plan_add(input int rail, input bit on);
    pr.push_back(rail);
    pon.push_back(on);
  endtask

  // Each planned rail flips at the running sum of (delay+1) of the steps before it.
  task automatic run_plan(input string tag, input logic [N-1:0] init, input logic [2:0] mid_st,
                          input logic [2:0] end_st, input int ncyc, input bit scramble);
    int t, acc;
    logic [N-1:0] exp_en;
    logic [2:0] exp_st;
    t = plan_total();
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_en = init;
      acc = 0;
      foreach (pr[i]) begin
        if (acc <= k) exp_en[pr[i]] = pon[i];
        acc += d[pr[i]] + 1;
      end
      exp_st = (k < t) ? mid_st : end_st;
      check($sformatf("%s rail_en k=%0d", tag, k), 32'(rail_en), 32'(exp_en));
      check($sformatf("%s state k=%0d", tag, k), 32'(state), 32'(exp_st));
      check($sformatf("%s ready k=%0d", tag, k), 32'(ready), 32'(exp_st == ACTIVE));
      check($sformatf("%s fault k=%0d", tag, k), 32'(fault), 32'(1'b0));
      if (scramble && k == 0) lp_keep = N'($urandom);
    end
  endtask

  task automatic plan_up_all();
    plan_clear();
    for (int i = 0; i < N; i++) plan_add(i, 1'b1);
  endtask

  task automatic tick_check_state(input string tag, input logic [2:0] exp_st);
    @(posedge clk);
    @(negedge clk);
    check(tag, 32'(state), 32'(exp_st));
  endtask

  initial begin
    reset = 1'b1; on_sw = 1'b0; lp_sw = 1'b0; lb_sw = 1'b0;
    lp_keep = '0; pg_kill = '0; dly_cfg = '0;
    repeat (2) @(negedge clk);
    check("rst state", 32'(state), 32'(OFF));
    check("rst rail_en", 32'(rail_en), 32'(0));
    check("rst ready", 32'(ready), 32'(0));
    check("rst fault", 32'(fault), 32'(0));
    check("rst fault_rail", 32'(fault_rail), 32'(0));
    reset = 1'b0;

    for (int it = 0; it < 3; it++) begin
      // Power-up from OFF
      new_dly(0);
      on_sw = 1'b1;
      plan_up_all();
      run_plan("up", '0, UP, ACTIVE, plan_total() + 3, 1'b0);

      // Low-power round trip; lp_keep is scrambled after the partial DOWN starts
      keep = (it == 0) ? N'(4'b0101) : N'($urandom);
      lp_keep = keep;
      lp_sw = 1'b1;
      plan_clear();
      for (int i = N - 1; i >= 0; i--) if (!keep[i]) plan_add(i, 1'b0);
      run_plan("lp_dn", {N{1'b1}}, DOWN, LP, plan_total() + 3, 1'b1);
      new_dly(0);
      lp_sw = 1'b0;
      plan_clear();
      for (int i = 0; i < N; i++) if (!keep[i]) plan_add(i, 1'b1);
      run_plan("lp_up", keep, UP, ACTIVE, plan_total() + 3, 1'b0);

      // One-cycle pgood glitch is tolerated, two cycles fault on the lowest rail
      m = N'($urandom_range(15, 1));
      low = '0;
      for (int i = N - 1; i >= 0; i--) if (m[i]) low = N'(1) << i;
      pg_kill = m;
      tick_check_state("glitch c1", ACTIVE);
      pg_kill = '0;
      tick_check_state("glitch c2", ACTIVE);
      tick_check_state("glitch c3", ACTIVE);
      pg_kill = m;
      tick_check_state("loss c1", ACTIVE);
      tick_check_state("loss c2", FLT);
      check("loss rail_en", 32'(rail_en), 32'(0));
      check("loss fault", 32'(fault), 32'(1));
      check("loss ready", 32'(ready), 32'(0));
      check("loss fault_rail", 32'(fault_rail), 32'(low));
      pg_kill = '0;
      on_sw = 1'b0;
      tick_check_state("loss exit", OFF);
      check("loss exit fault", 32'(fault), 32'(0));
      check("loss exit fault_rail", 32'(fault_rail), 32'(low));

      // Re-power, then reset in the middle of DOWN
      on_sw = 1'b1;
      plan_up_all();
      run_plan("repwr", '0, UP, ACTIVE, plan_total() + 2, 1'b0);
      check("fault_rail hold", 32'(fault_rail), 32'(low));
      on_sw = 1'b0;
      tick_check_state("pre-rst down", DOWN);
      #2 reset = 1'b1;
      #1;
      check("async rst state", 32'(state), 32'(OFF));
      check("async rst rail_en", 32'(rail_en), 32'(0));
      check("async rst ready", 32'(ready), 32'(0));
      check("async rst fault", 32'(fault), 32'(0));
      check("async rst fault_rail", 32'(fault_rail), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      on_sw = 1'b1;
      plan_up_all();
      run_plan("rst_up", '0, UP, ACTIVE, plan_total() + 3, 1'b0);

      // lb_sw and lp_sw together: full DOWN, then lb_sw holds OFF
      lb_sw = 1'b1;
      lp_sw = 1'b1;
      lp_keep = N'($urandom);
      plan_clear();
      for (int i = N - 1; i >= 0; i--) plan_add(i, 1'b0);
      run_plan("lb_dn", {N{1'b1}}, DOWN, OFF, plan_total() + 3, 1'b0);
      plan_clear();
      run_plan("lb_hold", '0, OFF, OFF, 5, 1'b0);

      // pgood[2] never rises: FAULT after dly+1+PG_TO cycles of rail 2's step
      lb_sw = 1'b0;
      lp_sw = 1'b0;
      new_dly(0);
      pg_kill = N'(4'b0100);
      plan_clear();
      for (int i = 0; i < 3; i++) plan_add(i, 1'b1);
      t2 = d[0] + d[1] + 2;
      run_plan("pg_to", '0, UP, UP, t2 + d[2] + 1 + PG_TO, 1'b0);
      tick_check_state("pg_to state", FLT);
      check("pg_to rail_en", 32'(rail_en), 32'(0));
      check("pg_to fault", 32'(fault), 32'(1));
      check("pg_to fault_rail", 32'(fault_rail), 32'(4'b0100));
      on_sw = 1'b0;
      pg_kill = '0;
      tick_check_state("pg_to exit", OFF);
      check("pg_to exit fault", 32'(fault), 32'(0));

      // on_sw falls while rail 2 is still in its delay
      new_dly(1);
      r = int'($urandom_range(d[2] - 1, 0));
      on_sw = 1'b1;
      plan_clear();
      for (int i = 0; i < 3; i++) plan_add(i, 1'b1);
      t2 = d[0] + d[1] + 2;
      run_plan("ab_up", '0, UP, UP, t2 + r + 1, 1'b0);
      on_sw = 1'b0;
      plan_clear();
      for (int i = 2; i >= 0; i--) plan_add(i, 1'b0);
      run_plan("ab_dn", N'(4'b0111), DOWN, OFF, plan_total() + 3, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
